// File: rtl/jk_universal_reg_if.sv
// Bus bundle for jk_universal_reg: control/data inputs and register outputs.
interface jk_universal_reg_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             ser_in;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, J, K, ser_in,
        input  Q, tc, wrap
    );

    modport slave (
        input  en, mode, J, K, ser_in,
        output Q, tc, wrap
    );
endinterface

// File: rtl/jk_universal_reg.sv
// Universal register: per-bit JK, parallel load, modulo up/down count, shift and rotate.
module jk_universal_reg #(
    parameter int unsigned     WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    jk_universal_reg_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_JK    = 3'b001,
        MODE_LOAD  = 3'b010,
        MODE_UP    = 3'b011,
        MODE_DOWN  = 3'b100,
        MODE_SHL   = 3'b101,
        MODE_SHR   = 3'b110,
        MODE_ROL   = 3'b111
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    assign mode_s = mode_e'(bus.mode);

    // Next-state and wrap-pulse decode; en=0 holds Q and clears wrap.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.en) begin
            unique case (mode_s)
                MODE_HOLD: q_d = q_q;
                MODE_JK:   q_d = (bus.J & ~q_q) | (~bus.K & q_q);
                MODE_LOAD: q_d = bus.J;
                MODE_UP: begin
                    // Out-of-range values also wrap to zero.
                    if (q_q >= MAX_COUNT) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q_q == '0) begin
                        q_d    = MAX_COUNT;
                        wrap_d = 1'b1;
                    end else if (q_q > MAX_COUNT) begin
                        q_d = MAX_COUNT;
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.ser_in};
                MODE_SHR:  q_d = {bus.ser_in, q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count looks at the current mode and Q only, regardless of en.
    assign bus.tc   = ((mode_s == MODE_UP)   && (q_q == MAX_COUNT)) ||
                      ((mode_s == MODE_DOWN) && (q_q == '0));
    assign bus.Q    = q_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_universal_reg.sv
// Directed self-checking bench for jk_universal_reg (WIDTH=4, MAX_COUNT=9).
module tb_jk_universal_reg;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    jk_universal_reg_if #(.WIDTH(4)) bus ();

    jk_universal_reg #(
        .WIDTH     (4),
        .MAX_COUNT (4'd9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] val);
        bus.mode = 3'b010;
        bus.J    = val;
        step();
        chk("load", 32'(bus.Q), 32'(val));
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] exp_q;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.en     = 1'b1;
        bus.mode   = 3'b011;
        bus.J      = 4'b0000;
        bus.K      = 4'b0000;
        bus.ser_in = 1'b0;

        // Reset overrides en/mode; tc follows Q=0 at once.
        step();
        chk("rst_q", 32'(bus.Q), 32'h0);
        chk("rst_wrap", 32'(bus.wrap), 32'h0);
        chk("rst_tc_up", 32'(bus.tc), 32'h0);
        bus.mode = 3'b100;
        #1;
        chk("rst_tc_down", 32'(bus.tc), 32'h1);

        // Per-bit JK: set/clear, toggle, hold.
        reset    = 1'b0;
        bus.mode = 3'b001;
        bus.J    = 4'b1010;
        bus.K    = 4'b0101;
        step();
        chk("jk_setclr", 32'(bus.Q), 32'hA);
        bus.J = 4'b1111;
        bus.K = 4'b1111;
        step();
        chk("jk_toggle", 32'(bus.Q), 32'h5);
        bus.J = 4'b0000;
        bus.K = 4'b0000;
        step();
        chk("jk_hold", 32'(bus.Q), 32'h5);

        // Mode 000 holds.
        bus.mode = 3'b000;
        bus.J    = 4'b1111;
        step();
        chk("hold", 32'(bus.Q), 32'h5);

        // Count up 12 edges from 0: 1..9,0,1,2.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        bus.mode = 3'b011;
        bus.K    = 4'b1111;
        prev     = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            chk("up_tc", 32'(bus.tc), (prev == 4'd9) ? 32'h1 : 32'h0);
            step();
            exp_q = 4'(i % 10);
            chk("up_q", 32'(bus.Q), 32'(exp_q));
            chk("up_wrap", 32'(bus.wrap), (prev == 4'd9) ? 32'h1 : 32'h0);
            prev = exp_q;
        end

        // Out-of-range value: up wraps with pulse, down saturates to 9 silently.
        load(4'd12);
        chk("oor_ld_wrap", 32'(bus.wrap), 32'h0);
        bus.mode = 3'b011;
        step();
        chk("oor_up_q", 32'(bus.Q), 32'h0);
        chk("oor_up_wrap", 32'(bus.wrap), 32'h1);
        load(4'd12);
        bus.mode = 3'b100;
        #1;
        chk("oor_dn_tc", 32'(bus.tc), 32'h0);
        step();
        chk("oor_dn_q", 32'(bus.Q), 32'h9);
        chk("oor_dn_wrap", 32'(bus.wrap), 32'h0);

        // Count down from 0 wraps to 9; then en=0 holds for 3 edges.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("dn_tc_pre", 32'(bus.tc), 32'h1);
        step();
        chk("dn_q", 32'(bus.Q), 32'h9);
        chk("dn_wrap", 32'(bus.wrap), 32'h1);
        step();
        chk("dn_q2", 32'(bus.Q), 32'h8);
        chk("dn_wrap2", 32'(bus.wrap), 32'h0);
        load(4'd9);
        bus.mode = 3'b011;
        bus.en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("en0_tc", 32'(bus.tc), 32'h1);
            step();
            chk("en0_q", 32'(bus.Q), 32'h9);
            chk("en0_wrap", 32'(bus.wrap), 32'h0);
        end
        bus.en = 1'b1;

        // Shift left with ser_in=1, J/K ignored.
        reset = 1'b1;
        step();
        reset      = 1'b0;
        bus.mode   = 3'b101;
        bus.ser_in = 1'b1;
        bus.J      = 4'b0101;
        bus.K      = 4'b1010;
        step();
        chk("shl1", 32'(bus.Q), 32'h1);
        step();
        chk("shl2", 32'(bus.Q), 32'h3);
        step();
        chk("shl3", 32'(bus.Q), 32'h7);
        step();
        chk("shl4", 32'(bus.Q), 32'hF);

        // Rotate left and shift right.
        load(4'b1000);
        bus.mode = 3'b111;
        step();
        chk("rol", 32'(bus.Q), 32'h1);
        step();
        chk("rol2", 32'(bus.Q), 32'h2);
        load(4'b1111);
        bus.mode   = 3'b110;
        bus.ser_in = 1'b0;
        step();
        chk("shr", 32'(bus.Q), 32'h7);
        bus.ser_in = 1'b1;
        step();
        chk("shr_in1", 32'(bus.Q), 32'hB);

        // Reset mid-count at Q=7, then resume from 0.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        bus.mode = 3'b011;
        for (int i = 0; i < 7; i++) step();
        chk("mid_q7", 32'(bus.Q), 32'h7);
        reset = 1'b1;
        step();
        chk("mid_rst_q", 32'(bus.Q), 32'h0);
        chk("mid_rst_wrap", 32'(bus.wrap), 32'h0);
        reset = 1'b0;
        step();
        chk("mid_resume", 32'(bus.Q), 32'h1);

        // Reset pulse between edges is not sampled.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        chk("glitch_rst", 32'(bus.Q), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_universal_reg.md
JK_UNIVERSAL_REG -- requirements
Module: jk_universal_reg

Interface
REQ-001 Parameter: WIDTH, default 4, register width in bits (legal 2..32).
REQ-002 Parameter: MAX_COUNT, default 2**WIDTH-1, counter terminal value (legal 1..2**WIDTH-1).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  operation enable; 0 = hold all state.
REQ-006 Port: mode  input  3  operation select (see REQ-012).
REQ-007 Port: J  input  WIDTH  per-bit J inputs; also parallel-load data in D mode.
REQ-008 Port: K  input  WIDTH  per-bit K inputs.
REQ-009 Port: ser_in  input  1  serial input for shift modes.
REQ-010 Port: Q  output  WIDTH  registered register state.
REQ-011 Port: tc  output  1  combinational terminal-count flag; wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-012 Mode decode: 000 hold; 001 per-bit JK; 010 D load (Q<=J); 011 count up; 100 count down; 101 shift left (ser_in into bit 0); 110 shift right (ser_in into bit WIDTH-1); 111 rotate left (bit WIDTH-1 into bit 0).
REQ-013 JK mode, each bit i independently: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-014 K ignored in all modes except 001; J ignored in all modes except 001 and 010; ser_in ignored except 101/110.
REQ-015 Count up: Q<MAX_COUNT -> Q+1; Q>=MAX_COUNT -> 0 (covers out-of-range values loaded via D mode).
REQ-016 Count down: Q==0 or Q>MAX_COUNT -> MAX_COUNT; else Q-1.
REQ-017 Arithmetic modulo MAX_COUNT+1; no intermediate result wider than WIDTH+1 bits reaches Q.
REQ-018 tc = 1 when (mode==011 and Q==MAX_COUNT) or (mode==100 and Q==0); else 0; independent of en.
REQ-019 wrap asserted for exactly one cycle following any edge where en=1 and a count wraps (up: MAX_COUNT->0 or out-of-range->0; down: 0->MAX_COUNT); 0 otherwise.
REQ-020 en=0: Q held, wrap driven 0 next cycle, tc still combinational.
REQ-021 Mode change takes effect on the same edge it is sampled; no pipeline latency; Q updates one edge after inputs.
REQ-022 Shift/rotate perform exactly one bit position per enabled edge.

Reset
REQ-023 reset=1 at a rising edge: Q<=0, wrap<=0, overriding en and mode.
REQ-024 reset sampled only on clk rising edge; reset asserted between edges has no effect on Q until the next edge.
REQ-025 reset mid-count: next edge Q=0; counting resumes from 0 on first edge with reset=0.
REQ-026 After reset, tc reflects Q=0 immediately (e.g. 1 if mode==100).

Verification (WIDTH=4, MAX_COUNT=9)
REQ-027 Reset then mode=001, J=1010, K=0101 -> Q=1010; then J=K=1111 -> Q=0101; then J=K=0000 -> Q holds 0101.
REQ-028 mode=011 from Q=0, 12 edges -> Q sequence 1..9,0,1,2; tc=1 while Q=9; wrap=1 only on the cycle after 9->0.
REQ-029 mode=010 J=1100 (12) then mode=011 -> Q=0, wrap pulses; mode=010 J=1100 then mode=100 -> Q=9, no wrap pulse.
REQ-030 mode=100 from Q=0 -> Q=9, wrap pulse; tc=1 before edge; en=0 for 3 edges -> Q stays 9, wrap 0.
REQ-031 mode=101, ser_in=1 from Q=0000 -> 0001,0011,0111,1111; mode=111 on 1000 -> 0001; mode=110 ser_in=0 on 1111 -> 0111.
REQ-032 Counting at Q=7, reset=1 for one edge with en=1 -> Q=0, wrap=0; reset released -> Q=1 next edge.
